// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one read at a time, holds the word for decode.
// Optional IFU_EBREAK_HALT_EN: an accepted ebreak parks the unit in HALT until reset.
module ifu_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [31:0]       resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt
);

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT} state_t;
`endif

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic                flush, flush_n;
  logic [31:0]         inst_q, inst_n;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_n;
  logic                halted;

`ifdef IFU_EBREAK_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      flush     <= flush_n;
      inst_q    <= inst_n;
      inst_pc_q <= inst_pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    flush_n   = flush;
    inst_n    = inst_q;
    inst_pc_n = inst_pc_q;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (req_ready) begin
          state_n = WAIT;
          // old-pc request is already out; its response must be dropped
          flush_n = redirect_valid;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          flush_n = 1'b0;
          if (flush || redirect_valid) begin
            state_n = REQ;
          end else begin
            state_n   = OUT;
            inst_n    = resp_data;
            inst_pc_n = pc;
          end
        end else if (redirect_valid) begin
          flush_n = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          state_n = REQ;
        end else if (inst_ready) begin
          pc_n    = pc + ADDR_W'(4);
`ifdef IFU_EBREAK_HALT_EN
          state_n = (inst_q == EBREAK) ? HALT : REQ;
`else
          state_n = REQ;
`endif
        end
      end
`ifdef IFU_EBREAK_HALT_EN
      HALT: state_n = HALT;
`endif
      default: state_n = IDLE;
    endcase
    if (redirect_valid && !halted) pc_n = redirect_pc;
  end

  assign req_valid  = (state == REQ);
  assign req_addr   = req_valid ? pc : '0;
  assign inst_valid = (state == OUT);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halt       = halted;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run
// against a PC-sequence reference model and a latency-randomized memory.
module tb_ifu_fetch;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int vectors = 0;
  int miscompares = 0;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] d;
    d = {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E ^ (a * 7);
    if (d == EBREAK) d = ~d;
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_ready = 0; resp_valid = 0; resp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // From IDLE/REQ, push one zero-wait fetch through to OUT.
  task automatic deliver(input logic [31:0] d);
    int n = 0;
    req_ready = 1;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!req_valid) begin
      vectors++; miscompares++;
      $display("FAIL deliver_req_timeout req_valid=%b want 1", req_valid);
    end
    tick();
    req_ready = 0;
    resp_valid = 1;
    resp_data = d;
    tick();
    resp_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    resp_valid = 1;
    resp_data = 32'hDEAD_BEEF;
    tick();
    tick();
    vectors++;
    if ({req_valid, inst_valid, halt} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 000",
               {req_valid, inst_valid, halt});
    end
    vectors++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_inst got %h/%h want 0/0", inst, inst_pc);
    end
    resp_valid = 0;
    rst = 0;
  endtask

  task automatic test_basic;
    do_reset();
    req_ready = 1;
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL basic_req got %b/%h want 1/80000000",
               req_valid, req_addr);
    end
    tick();
    vectors++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait got %b/%b want 0/0", req_valid, inst_valid);
    end
    req_ready = 0;
    resp_valid = 1;
    resp_data = ADDI;
    tick();
    resp_valid = 0;
    vectors++;
    if (inst_valid !== 1'b1 || inst !== ADDI ||
        inst_pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL basic_out got %b/%h/%h want 1/%h/80000000",
               inst_valid, inst, inst_pc, ADDI);
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004 ||
        inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_next got %b/%h/%b want 1/80000004/0",
               req_valid, req_addr, inst_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    d = 32'h1234_5013;
    deliver(d);
    inst_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || req_valid !== 1'b0 || inst !== d ||
          inst_pc !== 32'h8000_0004) begin
        miscompares++;
        $display("FAIL bp_hold%0d got %b/%b/%h/%h want 1/0/%h/80000004",
                 i, inst_valid, req_valid, inst, inst_pc, d);
      end
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0008) begin
      miscompares++;
      $display("FAIL bp_release got %b/%h want 1/80000008",
               req_valid, req_addr);
    end
  endtask

  task automatic test_redirect_wait;
    req_ready = 1;
    tick();
    req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 0;
    tick();
    resp_valid = 1;
    resp_data = 32'hBAD0_0013;
    tick();
    resp_valid = 0;
    vectors++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 ||
        req_addr !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL rdw_next got %b/%b/%h want 0/1/80000100",
               inst_valid, req_valid, req_addr);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdw_drop inst_valid=%b want 0", inst_valid);
    end
  endtask

  task automatic test_redirect_out;
    deliver(32'h0000_0113);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL rdo_held got %b/%h want 1/80000100", inst_valid, inst_pc);
    end
    inst_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 0;
    redirect_valid = 0;
    vectors++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 ||
        req_addr !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL rdo_next got %b/%b/%h want 0/1/80000200",
               inst_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_wrap;
    req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_req got %b/%h want 1/fffffffc", req_valid, req_addr);
    end
    deliver(32'h0020_0193);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_inst got %b/%h want 1/fffffffc", inst_valid, inst_pc);
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    vectors++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_next got %b/%h want 1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_mid_reset;
    req_ready = 1;
    tick();
    req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    vectors++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      miscompares++;
      $display("FAIL mrst_idle got %b/%b/%h want 0/0/0",
               req_valid, inst_valid, inst);
    end
    resp_valid = 1;
    resp_data = 32'hBAD1_0013;
    tick();
    tick();
    resp_valid = 0;
    vectors++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 ||
        req_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL mrst_late got %b/%b/%h want 0/1/80000000",
               inst_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_ebreak;
    do_reset();
    deliver(EBREAK);
    inst_ready = 1;
    tick();
    inst_ready = 0;
`ifdef IFU_EBREAK_HALT_EN
    vectors++;
    if (halt !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ebreak_halt got %b/%b/%b want 1/0/0",
               halt, req_valid, inst_valid);
    end
    redirect_valid = 1;
    redirect_pc = 32'h8000_0400;
    req_ready = 1;
    tick();
    redirect_valid = 0;
    tick();
    tick();
    req_ready = 0;
    vectors++;
    if (halt !== 1'b1 || req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ebreak_redir got %b/%b want 1/0", halt, req_valid);
    end
    rst = 1;
    tick();
    rst = 0;
    vectors++;
    if (halt !== 1'b0) begin
      miscompares++;
      $display("FAIL ebreak_rst halt=%b want 0", halt);
    end
`else
    vectors++;
    if (halt !== 1'b0 || req_valid !== 1'b1 ||
        req_addr !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL ebreak_plain got %b/%b/%h want 0/1/80000004",
               halt, req_valid, req_addr);
    end
`endif
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] pa[$];
    int          pd[$];
    logic        hold;
    logic [31:0] hold_inst, hold_pc;
    int          idle;
    int          delivered;
    exp_pc = 32'h8000_0000;
    hold = 0;
    hold_inst = 0;
    hold_pc = 0;
    idle = 0;
    delivered = 0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (req_valid && pa.size() != 0) begin
        vectors++; miscompares++;
        $display("FAIL rnd_outstanding cyc=%0d pending=%0d want 0",
                 cyc, pa.size());
      end
      if (hold) begin
        vectors++;
        if (inst_valid !== 1'b1 || inst !== hold_inst ||
            inst_pc !== hold_pc) begin
          miscompares++;
          $display("FAIL rnd_hold cyc=%0d got %b/%h/%h want 1/%h/%h",
                   cyc, inst_valid, inst, inst_pc, hold_inst, hold_pc);
        end
      end
      req_ready = ($urandom % 3) != 0;
      inst_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      case ($urandom % 3)
        0: redirect_pc = {$urandom} & 32'hFFFF_FFFC;
        1: redirect_pc = 32'hFFFF_FFF0 + 4 * ($urandom % 4);
        default: redirect_pc = 32'h8000_0000 + 4 * ($urandom % 64);
      endcase
      resp_valid = 0;
      resp_data = $urandom;
      if (pa.size() != 0) begin
        if (pd[0] == 0) begin
          resp_valid = 1;
          resp_data = mem(pa[0]);
          void'(pa.pop_front());
          void'(pd.pop_front());
        end else begin
          pd[0] = pd[0] - 1;
        end
      end else begin
        resp_valid = ($urandom % 8) == 0;
      end
      if (req_valid && req_ready) begin
        pa.push_back(req_addr);
        pd.push_back(int'($urandom % 4));
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mem(exp_pc)) begin
          miscompares++;
          $display("FAIL rnd_deliver cyc=%0d got %h@%h want %h@%h",
                   cyc, inst, inst_pc, mem(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + 4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      hold = inst_valid && !inst_ready && !redirect_valid;
      hold_inst = inst;
      hold_pc = inst_pc;
      if (idle > 300) begin
        vectors++; miscompares++;
        $display("FAIL rnd_stall cyc=%0d idle=%0d want <=300", cyc, idle);
        break;
      end
      tick();
    end
    clear_inputs();
    vectors++;
    if (delivered < 100) begin
      miscompares++;
      $display("FAIL rnd_progress delivered=%0d want >=100", delivered);
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_mid_reset();
    test_ebreak();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: the producer end of the instruction interface that the decode stage consumes.
- Owns the PC and issues one word-aligned read per instruction to instruction memory.
- Captures the returned word and holds it with a valid/ready handshake until decode accepts it.
- Accepts PC redirects (jumps/branches) and discards any in-flight stale response.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request this cycle
- req_addr  out  ADDR_W  fetch address (current PC)
- resp_valid  in  1  memory returns read data this cycle
- resp_data  in  32  instruction word from memory
- inst_valid  out  1  instruction held for decode
- inst_ready  in  1  decode accepts held instruction
- inst  out  32  instruction word to decode
- inst_pc  out  ADDR_W  PC of held instruction
- redirect_valid  in  1  single-cycle PC redirect pulse
- redirect_pc  in  ADDR_W  redirect target
- halt  out  1  fetch stopped (see Optional Feature)

Behaviour:
- One clock domain (clk); reset (rst) is synchronous, active-high; all listed outputs are decoded from registered state.
- While rst=1: state=IDLE, pc=RESET_PC, flush=0, inst/inst_pc=0, all outputs 0.
- States:
  - IDLE: no request; unconditionally go to REQ next cycle.
  - REQ: req_valid=1, req_addr=pc. If req_ready=1, go to WAIT.
  - WAIT: waiting for the response. On resp_valid with flush=0: inst<=resp_data, inst_pc<=pc, go to OUT. On resp_valid with flush=1: clear flush, drop the data, go to REQ.
  - OUT: inst_valid=1, and inst/inst_pc stay stable until the handshake. On inst_ready=1: pc<=pc+4, go to REQ.
- Fetch latency: at least 3 cycles from REQ entry to inst_valid (REQ, WAIT, OUT, with zero-wait memory). Exactly one outstanding request at any time.
- pc+4 is computed modulo 2^ADDR_W: 32'hFFFF_FFFC wraps to 0.
- resp_valid outside WAIT is ignored.
- Redirect (redirect_valid=1) always loads pc<=redirect_pc; redirect has priority over pc+4. Per state:
  - IDLE: load pc only; next state is REQ.
  - REQ with req_ready=0: stay in REQ with the new pc.
  - REQ with req_ready=1: the request at the old pc was issued, so set flush=1 and go to WAIT.
  - WAIT with resp_valid=0: set flush=1.
  - WAIT with resp_valid=1: drop that response and go to REQ.
  - OUT: drop the held instruction even if inst_ready=1 in the same cycle; go to REQ and deassert inst_valid next cycle.
- redirect_pc[1:0] is not checked; pc is loaded as given.
- rst mid-operation: immediate return to the reset values. Any late response then arrives in IDLE/REQ and is ignored.

Optional Feature:
- Macro: IFU_EBREAK_HALT_EN.
- Defined:
  - When an instruction equal to 32'h0010_0073 (ebreak) completes the OUT handshake, enter HALT.
  - In HALT: halt=1, req_valid=0, inst_valid=0. Redirects are ignored; only rst exits HALT.
- Not defined: no HALT state, halt tied to 0, ebreak is fetched like any other word.

Test Plan:
- Reset, then zero-wait memory returning 32'h0010_0093 (addi): first req_addr=32'h8000_0000; inst_valid after 3 cycles with inst_pc=32'h8000_0000; after handshake next req_addr=32'h8000_0004.
- Backpressure: hold inst_ready=0 for 5 cycles in OUT → inst and inst_pc stay constant, req_valid=0 throughout; on release, the next request goes out at pc+4.
- Redirect in WAIT to 32'h8000_0100, response arriving 2 cycles later → that response is dropped (inst_valid stays 0), next req_addr=32'h8000_0100.
- Redirect in OUT with inst_ready=1 in the same cycle → inst_valid=0 next cycle, next req_addr=redirect_pc, not old pc+4.
- Wrap: redirect to 32'hFFFF_FFFC, deliver and accept the instruction → next req_addr=32'h0000_0000.
- With IFU_EBREAK_HALT_EN: deliver 32'h0010_0073 and accept it → halt=1 on the next cycle, no further req_valid; a redirect pulse has no effect; rst clears halt.
